// File: rtl/multicyc_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicyc_datapath_if
//  Purpose  : Bundles the control, status and memory signals between the
//             multicycle MIPS datapath and its controller/memory environment.
//  Modports : master - controller + memory side (drives selects/enables and
//                      mem_rdata; observes opcode, memory request, ovf_exc)
//             slave  - datapath side
//  Revision : 1.0 - initial release
// ============================================================================
interface multicyc_datapath_if;
   // controller -> datapath
   logic        mem_addr_sel;
   logic        ir_we;
   logic        alu_srca_sel;
   logic [1:0]  alu_srcb_sel;
   logic [1:0]  aluop;
   logic        mem_rd;
   logic        mem_wr;
   logic        reg_we;
   logic        pc_we;
   logic        wreg_dst_sel;
   logic        wrbck_data_sel;
   // datapath -> controller / memory
   logic [5:0]  opcode;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_re;
   logic        mem_we;
   logic        ovf_exc;
   // memory -> datapath
   logic [31:0] mem_rdata;

   modport master (
      output mem_addr_sel, ir_we, alu_srca_sel, alu_srcb_sel, aluop,
             mem_rd, mem_wr, reg_we, pc_we, wreg_dst_sel, wrbck_data_sel,
             mem_rdata,
      input  opcode, mem_addr, mem_wdata, mem_re, mem_we, ovf_exc
   );

   modport slave (
      input  mem_addr_sel, ir_we, alu_srca_sel, alu_srcb_sel, aluop,
             mem_rd, mem_wr, reg_we, pc_we, wreg_dst_sel, wrbck_data_sel,
             mem_rdata,
      output opcode, mem_addr, mem_wdata, mem_re, mem_we, ovf_exc
   );
endinterface
`default_nettype wire

// File: rtl/multicyc_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : multicyc_datapath
//  Purpose  : Datapath of the multicycle MIPS core: PC, IR, MDR, A/B operand
//             latches, ALUOut, 32x32 register file and ALU, driving a unified
//             single-port instruction/data memory.
//  Ports    : clk   - clock, all state updates on posedge
//             reset - asynchronous active-high reset
//             bus   - multicyc_datapath_if.slave (controls in, opcode,
//                     memory request and sticky overflow flag out)
//  Params   : RESET_PC - PC value loaded on reset
//  Revision : 1.0 - initial release
// ============================================================================
module multicyc_datapath #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  wire logic          clk,
   input  wire logic          reset,
   multicyc_datapath_if.slave bus
);

   localparam logic [5:0] c_FN_ADD  = 6'h20;
   localparam logic [5:0] c_FN_ADDU = 6'h21;
   localparam logic [5:0] c_FN_SUB  = 6'h22;
   localparam logic [5:0] c_FN_SUBU = 6'h23;
   localparam logic [5:0] c_FN_AND  = 6'h24;
   localparam logic [5:0] c_FN_OR   = 6'h25;
   localparam logic [5:0] c_FN_SLT  = 6'h2a;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_mdr;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_aluout;
   logic        r_ovf_q;
   logic        r_ovf_exc;
   logic [31:0] r_rf [0:31];

   // ------------------------------------------------------------------------
   // Instruction fields and register-file read ports
   // ------------------------------------------------------------------------
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [5:0]  w_funct;
   logic [31:0] w_imm_sext;
   logic [31:0] w_rs_data;
   logic [31:0] w_rt_data;

   assign w_rs       = r_ir[25:21];
   assign w_rt       = r_ir[20:16];
   assign w_rd       = r_ir[15:11];
   assign w_funct    = r_ir[5:0];
   assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};

   // Register 0 is hardwired to zero on the read side.
   assign w_rs_data = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
   assign w_rt_data = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];

   // ------------------------------------------------------------------------
   // ALU
   // ------------------------------------------------------------------------
   logic [31:0] w_srca;
   logic [31:0] w_srcb;
   logic [31:0] w_sum;
   logic [31:0] w_diff;
   logic        w_add_ovf;
   logic        w_sub_ovf;
   logic        w_slt;
   logic [31:0] w_alu_res;
   logic        w_ovf;

   assign w_srca = bus.alu_srca_sel ? r_a : r_pc;

   always_comb begin
      w_srcb = r_b;
      case (bus.alu_srcb_sel)
         2'b00:   w_srcb = r_b;
         2'b01:   w_srcb = 32'd4;
         2'b10:   w_srcb = w_imm_sext;
         default: w_srcb = 32'd0;
      endcase
   end

   assign w_sum  = w_srca + w_srcb;
   assign w_diff = w_srca - w_srcb;
   // Signed overflow: same-sign operands (sub: A vs ~B) producing a result
   // whose sign differs from A.
   assign w_add_ovf = (w_srca[31] == w_srcb[31]) && (w_sum[31]  != w_srca[31]);
   assign w_sub_ovf = (w_srca[31] != w_srcb[31]) && (w_diff[31] != w_srca[31]);
   assign w_slt     = ($signed(w_srca) < $signed(w_srcb));

   always_comb begin
      w_alu_res = w_sum;
      w_ovf     = 1'b0;
      case (bus.aluop)
         2'b00: begin
            w_alu_res = w_sum;
            w_ovf     = w_add_ovf;
         end
         2'b10: begin
            case (w_funct)
               c_FN_ADD: begin
                  w_alu_res = w_sum;
                  w_ovf     = w_add_ovf;
               end
               c_FN_ADDU: w_alu_res = w_sum;
               c_FN_SUB: begin
                  w_alu_res = w_diff;
                  w_ovf     = w_sub_ovf;
               end
               c_FN_SUBU: w_alu_res = w_diff;
               c_FN_AND:  w_alu_res = w_srca & w_srcb;
               c_FN_OR:   w_alu_res = w_srca | w_srcb;
               c_FN_SLT:  w_alu_res = {31'd0, w_slt};
               default:   w_alu_res = 32'd0;
            endcase
         end
         default: w_alu_res = w_sum;   // 01 and 11 are both ADDU
      endcase
   end

   // ------------------------------------------------------------------------
   // Write-back: uses ALUOut/MDR/ovf_q registered in the previous cycle and
   // the pre-edge IR for the destination.
   // ------------------------------------------------------------------------
   logic [4:0]  w_wreg;
   logic [31:0] w_wdata;
   logic        w_ovf_block;
   logic        w_rf_we;

   assign w_wreg      = bus.wreg_dst_sel ? w_rd : w_rt;
   assign w_wdata     = bus.wrbck_data_sel ? r_mdr : r_aluout;
   // An ALU result that overflowed never reaches the register file.
   assign w_ovf_block = bus.reg_we && !bus.wrbck_data_sel && r_ovf_q;
   assign w_rf_we     = bus.reg_we && (w_wreg != 5'd0) && !w_ovf_block;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc      <= RESET_PC;
         r_ir      <= 32'd0;
         r_mdr     <= 32'd0;
         r_a       <= 32'd0;
         r_b       <= 32'd0;
         r_aluout  <= 32'd0;
         r_ovf_q   <= 1'b0;
         r_ovf_exc <= 1'b0;
         for (int i = 0; i < 32; i++) begin
            r_rf[i] <= 32'd0;
         end
      end else begin
         r_a      <= w_rs_data;
         r_b      <= w_rt_data;
         r_aluout <= w_alu_res;
         r_ovf_q  <= w_ovf;
         r_mdr    <= bus.mem_rdata;
         if (bus.ir_we) begin
            r_ir <= bus.mem_rdata;
         end
         if (bus.pc_we) begin
            r_pc <= w_alu_res;
         end
         if (w_rf_we) begin
            r_rf[w_wreg] <= w_wdata;
         end
         if (w_ovf_block) begin
            r_ovf_exc <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.opcode    = r_ir[31:26];
   assign bus.mem_addr  = bus.mem_addr_sel ? r_aluout : r_pc;
   assign bus.mem_wdata = r_b;
   assign bus.mem_re    = bus.mem_rd;
   assign bus.mem_we    = bus.mem_wr;
   assign bus.ovf_exc   = r_ovf_exc;

endmodule
`default_nettype wire

// File: tb/tb_multicyc_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicyc_datapath
//  Purpose  : Directed testbench for multicyc_datapath. Plays the role of the
//             multicycle controller and a word-addressed unified memory, and
//             walks hand-encoded instructions through fetch/decode/execute/
//             memory/write-back cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicyc_datapath;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   multicyc_datapath_if bus ();

   multicyc_datapath #(
      .RESET_PC (32'h0000_0040)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Word-addressed memory, combinational read
   logic [31:0] mem [0:63];
   assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] pc_m;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_we;

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
      return {6'h00, rs, rt, rd, 5'h00, funct};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input logic [4:0] idx, input logic [31:0] exp, input string tag);
      chk(tag, dut.r_rf[idx], exp);
   endtask

   task automatic ctl(input logic as, input logic ir, input logic sa,
                      input logic [1:0] sb, input logic [1:0] op,
                      input logic rd, input logic wr, input logic rw,
                      input logic pw, input logic ds, input logic ws);
      bus.mem_addr_sel   = as;
      bus.ir_we          = ir;
      bus.alu_srca_sel   = sa;
      bus.alu_srcb_sel   = sb;
      bus.aluop          = op;
      bus.mem_rd         = rd;
      bus.mem_wr         = wr;
      bus.reg_we         = rw;
      bus.pc_we          = pw;
      bus.wreg_dst_sel   = ds;
      bus.wrbck_data_sel = ws;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_fetch(input logic [31:0] instr);
      logic [5:0] op;
      op = instr[31:26];
      mem[pc_m[7:2]] = instr;
      ctl(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      pc_m = pc_m + 32'd4;
      chk("fetch_pc", bus.mem_addr, pc_m);
      chk("fetch_opcode", {26'd0, bus.opcode}, {26'd0, op});
   endtask

   task automatic do_decode();
      ctl(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic exec_i(input logic [1:0] op);
      ctl(1'b0, 1'b0, 1'b1, 2'b10, op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic exec_r();
      ctl(1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic wb(input logic ds, input logic ws);
      ctl(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, ds, ws);
      tick();
   endtask

   task automatic run_i(input logic [31:0] instr, input logic [1:0] op);
      do_fetch(instr);
      do_decode();
      exec_i(op);
      wb(1'b0, 1'b0);
   endtask

   task automatic run_r(input logic [31:0] instr);
      do_fetch(instr);
      do_decode();
      exec_r();
      wb(1'b1, 1'b0);
   endtask

   task automatic run_lw(input logic [31:0] instr);
      do_fetch(instr);
      do_decode();
      exec_i(2'b01);
      ctl(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      wb(1'b0, 1'b1);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      mem[4] = 32'h7FFF_FFFF;                 // data word at byte address 16
      pc_m   = 32'h0000_0040;
      ctl(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // ---------------- reset state ----------------
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_addr", bus.mem_addr, 32'h0000_0040);
      chk("rst_opcode", {26'd0, bus.opcode}, 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      chk("rst_ovf_exc", {31'd0, bus.ovf_exc}, 32'd0);
      for (int i = 0; i < 32; i++) chk_reg(5'(i), 32'd0, "rst_rf");
      reset = 1'b0;

      // ---------------- immediate arithmetic ----------------
      run_i(32'h2008_0005, 2'b00);                        // ADDI $8,$0,5
      chk_reg(5'd8, 32'd5, "addi_r8");
      run_i(enc_i(6'h08, 5'd0, 5'd9, 16'hFFFF), 2'b00);   // ADDI $9,$0,-1
      chk_reg(5'd9, 32'hFFFF_FFFF, "addi_r9");

      // ---------------- register-register ----------------
      run_r(enc_r(5'd8, 5'd9, 5'd10, 6'h22));             // SUB $10,$8,$9
      chk_reg(5'd10, 32'd6, "sub_r10");
      run_r(enc_r(5'd9, 5'd8, 5'd11, 6'h2a));             // SLT $11,$9,$8
      chk_reg(5'd11, 32'd1, "slt_r11");
      run_r(enc_r(5'd8, 5'd9, 5'd14, 6'h24));             // AND $14,$8,$9
      chk_reg(5'd14, 32'd5, "and_r14");
      run_r(enc_r(5'd8, 5'd9, 5'd10, 6'h3f));             // undefined funct
      chk_reg(5'd10, 32'd0, "badfn_r10");
      chk("no_ovf_yet", {31'd0, bus.ovf_exc}, 32'd0);

      // ---------------- store then load ----------------
      do_fetch(enc_i(6'h2b, 5'd0, 5'd8, 16'd8));          // SW $8,8($0)
      do_decode();
      exec_i(2'b01);
      ctl(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("sw_we", {31'd0, bus.mem_we}, 32'd1);
      chk("sw_re", {31'd0, bus.mem_re}, 32'd0);
      chk("sw_addr", bus.mem_addr, 32'd8);
      chk("sw_wdata", bus.mem_wdata, 32'd5);
      st_we   = bus.mem_we;
      st_addr = bus.mem_addr;
      st_data = bus.mem_wdata;
      @(posedge clk);
      if (st_we) mem[st_addr[7:2]] = st_data;
      #1;
      chk("sw_mem", mem[2], 32'd5);
      run_lw(enc_i(6'h23, 5'd0, 5'd13, 16'd8));           // LW $13,8($0)
      chk_reg(5'd13, 32'd5, "lw_r13");

      // ---------------- overflow ----------------
      run_lw(enc_i(6'h23, 5'd0, 5'd8, 16'd16));           // LW $8,16($0)
      chk_reg(5'd8, 32'h7FFF_FFFF, "lw_r8");
      run_i(enc_i(6'h08, 5'd8, 5'd12, 16'd1), 2'b00);     // ADDI $12,$8,1
      chk_reg(5'd12, 32'd0, "ovf_r12_kept");
      chk("ovf_exc_set", {31'd0, bus.ovf_exc}, 32'd1);
      run_i(enc_i(6'h09, 5'd8, 5'd12, 16'd1), 2'b01);     // ADDIU $12,$8,1
      chk_reg(5'd12, 32'h8000_0000, "addiu_r12");
      chk("ovf_exc_sticky", {31'd0, bus.ovf_exc}, 32'd1);

      // ---------------- write to $0 ----------------
      run_i(enc_i(6'h08, 5'd0, 5'd0, 16'd7), 2'b00);      // ADDI $0,$0,7
      chk_reg(5'd0, 32'd0, "r0_zero");

      // ---------------- reset during RR execute ----------------
      do_fetch(enc_r(5'd8, 5'd9, 5'd15, 6'h21));          // ADDU $15,$8,$9
      do_decode();
      ctl(1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      chk("mid_rst_pc", bus.mem_addr, 32'h0000_0040);
      chk("mid_rst_opcode", {26'd0, bus.opcode}, 32'd0);
      chk("mid_rst_ovf_exc", {31'd0, bus.ovf_exc}, 32'd0);
      chk_reg(5'd8, 32'd0, "mid_rst_r8");
      ctl(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      reset = 1'b0;
      wb(1'b1, 1'b0);
      chk_reg(5'd15, 32'd0, "post_rst_r15");
      chk_reg(5'd12, 32'd0, "post_rst_r12");
      chk("post_rst_pc", bus.mem_addr, 32'h0000_0040);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multicyc_datapath.md
# multicyc_datapath

Datapath for the multicycle MIPS core, driven cycle-by-cycle by the multicycle control FSM. It holds the PC, instruction register (IR), memory data register (MDR), operand latches A/B, ALUOut, a 32x32 register file and the ALU, and drives a unified single-port instruction/data memory. It returns the current opcode to the controller and applies the controller's select and enable signals on every edge.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- mem_addr_sel  in  1  memory address source: 0 = PC, 1 = ALUOut
- ir_we  in  1  load IR from mem_rdata
- alu_srca_sel  in  1  ALU A: 0 = PC, 1 = A latch (rs)
- alu_srcb_sel  in  2  ALU B: 00 = B latch (rt), 01 = 32'd4, 10 = sign-extended IR[15:0], 11 = 0
- aluop  in  2  00 = ADD (signed, overflow-checked), 01 = ADDU, 10 = RR (decode IR[5:0]), 11 = ADDU
- mem_rd  in  1  read strobe, passed to memory
- mem_wr  in  1  write strobe, passed to memory
- reg_we  in  1  register-file write enable
- pc_we  in  1  load PC from ALU result
- wreg_dst_sel  in  1  write register: 0 = IR[20:16] (rt), 1 = IR[15:11] (rd)
- wrbck_data_sel  in  1  write data: 0 = ALUOut, 1 = MDR
- opcode  out  6  IR[31:26]
- mem_addr  out  32  memory byte address
- mem_wdata  out  32  store data = B latch
- mem_re  out  1  = mem_rd
- mem_we  out  1  = mem_wr
- mem_rdata  in  32  memory read data, combinational from mem_addr
- ovf_exc  out  1  sticky arithmetic-overflow flag

## Operation
- ALU result combinational from srcA/srcB/aluop. RR funct map: 0x20 add (signed, ovf), 0x21 addu, 0x22 sub (signed, ovf), 0x23 subu, 0x24 and, 0x25 or, 0x2a slt (signed, result 0/1); any other funct -> result 0, no ovf.
- Overflow: signed, for add/sub only; ovf = operands same sign (sub: A and ~B) and result sign differs. ADDU/SUBU/logic never overflow.
- Every posedge, unconditionally: A <= rf[IR[25:21]], B <= rf[IR[20:16]], ALUOut <= ALU result, ovf_q <= ovf, MDR <= mem_rdata.
- Gated: IR <= mem_rdata when ir_we; PC <= ALU result when pc_we (ovf ignored for PC).
- Register write on posedge when reg_we, destination != 0, and not (wrbck_data_sel == 0 and ovf_q == 1). Suppressed overflow write sets ovf_exc <= 1; ovf_exc clears only on reset.
- rf[0] reads 0 always; writes to register 0 are discarded.
- Register file reads combinational; no write-to-read bypass (write at edge N visible to reads in cycle N+1).
- mem_addr = mem_addr_sel ? ALUOut : PC. No word-alignment check; low bits passed through.

## Timing
- Reset (async assert, removed synchronously by environment): PC = RESET_PC; IR, MDR, A, B, ALUOut, ovf_q, ovf_exc, all 32 registers = 0. Outputs during reset: opcode = 0, mem_addr = RESET_PC when mem_addr_sel = 0, mem_wdata = 0.
- Reset mid-instruction: all state cleared in the same cycle regardless of control inputs; no partial writes after assertion.
- Fetch cycle (ir_we, pc_we, srcA = PC, srcB = 4, ADD): IR and PC = PC+4 update at the same edge; opcode valid from the next cycle.
- Decode cycle: A/B capture rs/rt from new IR at end of decode.
- Address/execute cycle: ALUOut valid at the following cycle; load data captured into MDR one cycle after mem_addr_sel = 1 with mem_rd.
- Write-back uses ALUOut/MDR/ovf_q registered in the previous cycle.
- Simultaneous ir_we and reg_we: destination uses the old IR (pre-edge value).

## Test plan
- Reset with RESET_PC = 32'h0000_0040 -> PC = 0x40, mem_addr = 0x40, all registers read 0; one fetch with mem_rdata = 0x2008_0005 -> PC = 0x44, opcode = 0x08.
- ADDI $8,$0,5 full sequence (fetch, decode, exec ADD srcB = imm, writeback rt) -> rf[8] = 5; ADDI $9,$0,-1 -> rf[9] = 0xFFFF_FFFF.
- RR sub/slt: rf[8] = 5, rf[9] = -1; SUB $10,$8,$9 -> 6; SLT $11,$9,$8 -> 1; funct 0x3F -> rd written 0.
- Overflow: rf[8] = 0x7FFF_FFFF, ADDI $12,$8,1 -> rf[12] unchanged, ovf_exc = 1 and stays 1; ADDIU same operands -> rf[12] = 0x8000_0000.
- SW $8,8($0) then LW $13,8($0) against memory model -> mem_we pulse with mem_addr = 8, mem_wdata = rf[8]; rf[13] = rf[8] via MDR.
- Write to $0 (ADDI $0,$0,7) -> rf[0] still reads 0; assert reset during an RR exec cycle -> PC = RESET_PC, no register written at following edge.
